// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state encoding and operation constants for shift_seq_unit
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // sel encoding
    localparam logic SHIFT_LOG = 1'b0;  // logical shift, zero fill
    localparam logic SHIFT_ROT = 1'b1;  // rotate

    // dir encoding
    localparam logic DIR_LEFT  = 1'b0;  // toward MSB
    localparam logic DIR_RIGHT = 1'b1;  // toward LSB

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-position combinational shift/rotate step
// Ports: din  - N-bit input word
//        sel  - SHIFT_LOG (zero fill) or SHIFT_ROT (wrap the outgoing bit)
//        dir  - DIR_LEFT or DIR_RIGHT
//        dout - din moved by exactly one position
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    input  logic         sel,
    input  logic         dir,
    output logic [N-1:0] dout
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        dout = din;
        if (dir == DIR_LEFT) begin
            // The bit leaving at the MSB re-enters at the LSB when rotating.
            fill = (sel == SHIFT_ROT) ? din[N-1] : 1'b0;
            dout = {din[N-2:0], fill};
        end else begin
            fill = (sel == SHIFT_ROT) ? din[0] : 1'b0;
            dout = {fill, din[N-1:1]};
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - sequential shifter/rotator, one position per clock
// Ports: clk   - clock, rising edge
//        rst_n - synchronous active-low reset
//        start - request, sampled only in IDLE
//        A     - N-bit operand, captured on accepted start
//        B     - shift amount ($clog2(N) bits), captured on accepted start
//        sel   - SHIFT_LOG / SHIFT_ROT, captured on accepted start
//        dir   - DIR_LEFT / DIR_RIGHT, captured on accepted start
//        busy  - high whenever the FSM is not IDLE
//        done  - one-cycle pulse, Aout valid
//        Aout  - result register, updated only on entry to DONE
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N-1:0]         A,
    input  logic [$clog2(N)-1:0] B,
    input  logic                 sel,
    input  logic                 dir,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         Aout
);

    localparam int BW = $clog2(N);

    state_t          state;
    logic [N-1:0]    data_q;
    logic [BW-1:0]   cnt_q;
    logic            sel_q;
    logic            dir_q;
    logic [N-1:0]    step_out;

    shift_step #(.N(N)) u_step (
        .din  (data_q),
        .sel  (sel_q),
        .dir  (dir_q),
        .dout (step_out)
    );

    // busy and done are registered alongside the state so no input reaches
    // an output combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            sel_q  <= 1'b0;
            dir_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Aout   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data_q <= A;
                        cnt_q  <= B;
                        sel_q  <= sel;
                        dir_q  <= dir;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        data_q <= step_out;
                        cnt_q  <= cnt_q - BW'(1);
                    end else begin
                        Aout  <= data_q;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - self-checking bench for shift_seq_unit (N=8)
module tb_shift_seq_unit;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   A;
    logic [2:0]   B;
    logic         sel;
    logic         dir;
    logic         busy;
    logic         done;
    logic [7:0]   Aout;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_res = 8'h00;

    shift_seq_unit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .sel   (sel),
        .dir   (dir),
        .busy  (busy),
        .done  (done),
        .Aout  (Aout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] b;
        logic       s;
        logic       d;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: whole-word arithmetic over B positions, not a stepwise walk.
    function automatic logic [7:0] ref_op(input logic [7:0] a, input int b, input logic s, input logic d);
        int v;
        int k;
        v = int'(a);
        if (!s) begin
            v = d ? (v >> b) : ((v << b) & 255);
        end else begin
            k = b % 8;
            if (!d) v = ((v << k) | (v >> (8 - k))) & 255;
            else    v = ((v >> k) | (v << (8 - k))) & 255;
        end
        return v[7:0];
    endfunction

    // Issues one operation and watches the following B+4 cycles. While the
    // unit is busy (including its DONE cycle) the inputs are scrambled and
    // start is held high; none of that may disturb the result.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [2:0] b,
                          input logic s, input logic d, input logic [7:0] exp);
        int done_idx;
        int done_cnt;
        int busy_cnt;
        int hold_bad;
        logic [7:0] res_at_done;
        done_idx = -1;
        done_cnt = 0;
        busy_cnt = 0;
        hold_bad = 0;
        res_at_done = 8'h00;
        @(negedge clk);
        A = a; B = b; sel = s; dir = d; start = 1'b1;
        for (int k = 0; k <= int'(b) + 3; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx = k;
                    res_at_done = Aout;
                end
            end else if (busy && Aout !== prev_res) begin
                hold_bad++;
            end
            if (k <= int'(b) + 1) begin
                start = 1'b1;
                A = 8'h00;
                B = 3'($urandom_range(0, 7));
                sel = 1'($urandom);
                dir = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_done_edge"}, done_idx, int'(b) + 1);
        check({tag, "_done_width"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, int'(b) + 2);
        check({tag, "_aout"}, res_at_done, exp);
        check({tag, "_aout_hold"}, hold_bad, 0);
        prev_res = exp;
    endtask

    vec_t vecs[4];

    initial begin
        vec_t v;
        logic [7:0] ra;
        logic [2:0] rb;
        logic       rs;
        logic       rd;
        int         seen;

        vecs[0] = '{a: 8'hB3, b: 3'd3, s: 1'b0, d: 1'b0, exp: 8'h98};
        vecs[1] = '{a: 8'hB3, b: 3'd3, s: 1'b1, d: 1'b1, exp: 8'h76};
        vecs[2] = '{a: 8'hFF, b: 3'd7, s: 1'b0, d: 1'b1, exp: 8'h01};
        vecs[3] = '{a: 8'h5A, b: 3'd0, s: 1'b1, d: 1'b0, exp: 8'h5A};

        rst_n = 1'b0; start = 1'b1; A = 8'hFF; B = 3'd1; sel = 1'b0; dir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aout", Aout, 8'h00);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            v = vecs[i];
            run_op($sformatf("vec%0d", i), v.a, v.b, v.s, v.d, v.exp);
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 3'($urandom_range(0, 7));
            rs = 1'($urandom);
            rd = 1'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, rd, ref_op(ra, int'(rb), rs, rd));
        end

        // Reset in the middle of a long operation: no result, no later pulse.
        @(negedge clk);
        A = 8'hB3; B = 3'd7; sel = 1'b1; dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_aout", Aout, 8'h00);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrun_rst_no_done", seen, 0);
        check("midrun_rst_aout_after", Aout, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=1 want=0");
        $fatal(1);
    end

endmodule
